tspi_target: RTL and testbench

Byte-oriented TSPI target (SPI mode 0 responder) that is the far end of the SoC's TSPI master port (clock, MOSI, MISO, active-low chip select). It oversamples the master's serial lines in its own clock domain, decodes a command byte (read/write + 7-bit address), and issues single-cycle register-bus writes or reads with address auto-increment for bursts. It is used as an on-FPGA loopback peripheral for bring-up and as the device model for the TSPI master's regression.

---
 rtl/tspi_pkg.sv | 21 ++
 rtl/tspi_sync.sv | 45 ++++
 rtl/tspi_target.sv | 144 ++++++++++++++
 tb/tb_tspi_target.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tspi_pkg.sv
// Shared types and constants for the TSPI target and its input synchronizer.
package tspi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WDATA,
        RDATA
    } state_e;

    localparam int CmdRwBit  = 7;
    localparam int AddrWidth = 7;
    localparam int DataWidth = 8;

    // 7-bit address step; wraps 0x7F -> 0x00 naturally.
    function automatic logic [AddrWidth-1:0] addr_step(input logic [AddrWidth-1:0] addr,
                                                       input logic                 en);
        return addr + {{(AddrWidth-1){1'b0}}, en};
    endfunction

endpackage

// File: rtl/tspi_sync.sv
// Synchronizes SCLK/CS/data into clk, registers one-cycle SCLK edge pulses.
// CS and data get the same extra register so they stay aligned with the pulses.
module tspi_sync #(
    parameter int SyncStages = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic cs_n,
    input  logic sdata,
    output logic rise,
    output logic fall,
    output logic cs_n_sync,
    output logic sdata_sync
);

    logic [SyncStages-1:0] sclk_p0;
    logic [SyncStages-1:0] cs_p0;
    logic [SyncStages-1:0] data_p0;
    logic                  sclk_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_p0    <= '0;
            cs_p0      <= '1;
            data_p0    <= '0;
            sclk_p1    <= 1'b0;
            rise       <= 1'b0;
            fall       <= 1'b0;
            cs_n_sync  <= 1'b1;
            sdata_sync <= 1'b0;
        end else begin
            sclk_p0    <= {sclk_p0[SyncStages-2:0], sclk};
            cs_p0      <= {cs_p0[SyncStages-2:0], cs_n};
            data_p0    <= {data_p0[SyncStages-2:0], sdata};
            // edge-detect stage
            sclk_p1    <= sclk_p0[SyncStages-1];
            rise       <= sclk_p0[SyncStages-1] & ~sclk_p1;
            fall       <= ~sclk_p0[SyncStages-1] & sclk_p1;
            cs_n_sync  <= cs_p0[SyncStages-1];
            sdata_sync <= data_p0[SyncStages-1];
        end
    end

endmodule

// File: rtl/tspi_target.sv
// SPI mode 0 register-bus target: command byte {rw, addr}, then write or read
// data bytes with optional address auto-increment.
module tspi_target
    import tspi_pkg::*;
#(
    parameter int SyncStages = 2,
    parameter int AutoInc    = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 tspi_clk_i,
    input  logic                 tspi_cs_ni,
    input  logic                 tspi_mosi_i,
    output logic                 tspi_miso_o,
    output logic                 tspi_miso_oe_o,
    output logic [AddrWidth-1:0] addr_o,
    output logic                 wr_en_o,
    output logic [DataWidth-1:0] wdata_o,
    output logic                 rd_en_o,
    input  logic [DataWidth-1:0] rdata_i,
    output logic                 busy_o
);

    localparam logic IncEn        = (AutoInc != 0);
    localparam int   SettleCycles = SyncStages + 1;

    logic rise, fall, cs_n_sync, mosi_sync;

    tspi_sync #(.SyncStages(SyncStages)) u_sync (
        .clk       (clk_i),
        .rst       (rst_i),
        .sclk      (tspi_clk_i),
        .cs_n      (tspi_cs_ni),
        .sdata     (tspi_mosi_i),
        .rise      (rise),
        .fall      (fall),
        .cs_n_sync (cs_n_sync),
        .sdata_sync(mosi_sync)
    );

    state_e               state, state_n;
    logic [2:0]           bit_cnt, bit_cnt_n;
    logic [DataWidth-1:0] shift, shift_n, shift_in;
    logic [AddrWidth-1:0] addr_cnt, addr_cnt_n, addr_n;
    logic [DataWidth-1:0] wdata_n;
    logic                 wr_n, rd_n, byte_done;
    logic [7:0]           settle_cnt;
    logic                 settled, armed;

    // A frame may only start after CS has been seen genuinely high since reset,
    // so a CS already low at reset release is ignored.
    assign settled   = (settle_cnt == 8'(SettleCycles));
    assign shift_in  = {shift[DataWidth-2:0], mosi_sync};
    assign byte_done = rise && (bit_cnt == 3'd7);

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;
        addr_cnt_n = addr_cnt;
        addr_n     = addr_o;
        wdata_n    = wdata_o;
        wr_n       = 1'b0;
        rd_n       = 1'b0;
        if (state != IDLE && rise) bit_cnt_n = bit_cnt + 3'd1;
        case (state)
            IDLE: begin
                if (armed && !cs_n_sync) begin
                    state_n   = CMD;
                    bit_cnt_n = 3'd0;
                    shift_n   = '0;
                end
            end
            CMD: begin
                if (rise) shift_n = shift_in;
                if (byte_done) begin
                    addr_cnt_n = shift_in[AddrWidth-1:0];
                    if (shift_in[CmdRwBit]) begin
                        state_n = RDATA;
                        rd_n    = 1'b1;
                        addr_n  = shift_in[AddrWidth-1:0];
                    end else begin
                        state_n = WDATA;
                    end
                end
            end
            WDATA: begin
                if (rise) shift_n = shift_in;
                if (byte_done) begin
                    wr_n       = 1'b1;
                    wdata_n    = shift_in;
                    addr_n     = addr_cnt;
                    addr_cnt_n = addr_step(addr_cnt, IncEn);
                end
            end
            RDATA: begin
                if (byte_done) begin
                    addr_cnt_n = addr_step(addr_cnt, IncEn);
                    addr_n     = addr_cnt_n;
                    rd_n       = 1'b1;
                end else if (fall && bit_cnt != 3'd0) begin
                    shift_n = {shift[DataWidth-2:0], 1'b0};
                end
            end
            default: state_n = IDLE;
        endcase
        // Read data is only guaranteed during the strobe cycle, so capture it then.
        if (rd_en_o) shift_n = rdata_i;
        if (state != IDLE && cs_n_sync) state_n = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shift      <= '0;
            addr_cnt   <= '0;
            addr_o     <= '0;
            wdata_o    <= '0;
            wr_en_o    <= 1'b0;
            rd_en_o    <= 1'b0;
            settle_cnt <= 8'd0;
            armed      <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            addr_cnt   <= addr_cnt_n;
            addr_o     <= addr_n;
            wdata_o    <= wdata_n;
            wr_en_o    <= wr_n;
            rd_en_o    <= rd_n;
            settle_cnt <= settled ? settle_cnt : settle_cnt + 8'd1;
            armed      <= armed | (settled & cs_n_sync);
        end
    end

    // Bypass the shifter in the strobe cycle so bit 7 reaches MISO one cycle earlier.
    assign tspi_miso_oe_o = (state == RDATA);
    assign tspi_miso_o    = tspi_miso_oe_o ? (rd_en_o ? rdata_i[DataWidth-1] : shift[DataWidth-1])
                                           : 1'b0;
    assign busy_o         = ~cs_n_sync;

endmodule

// File: tb/tb_tspi_target.sv
// Scoreboard bench for tspi_target: master-side SPI driver at 8x clock ratio.
module tb_tspi_target;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, sclk, cs_n, mosi;
    logic       miso, oe, wr_en, rd_en, busy;
    logic [6:0] addr;
    logic [7:0] wdata, rdata;
    logic       miso2, oe2, wr2, rd2, busy2;
    logic [6:0] addr2;
    logic [7:0] wdata2, rdata2;

    assign rdata  = {1'b0, addr} ^ 8'h5A;
    assign rdata2 = {1'b0, addr2} ^ 8'h5A;

    tspi_target #(.SyncStages(2), .AutoInc(1)) dut (
        .clk_i(clk), .rst_i(rst), .tspi_clk_i(sclk), .tspi_cs_ni(cs_n), .tspi_mosi_i(mosi),
        .tspi_miso_o(miso), .tspi_miso_oe_o(oe), .addr_o(addr), .wr_en_o(wr_en),
        .wdata_o(wdata), .rd_en_o(rd_en), .rdata_i(rdata), .busy_o(busy)
    );

    tspi_target #(.SyncStages(2), .AutoInc(0)) dut_fixed (
        .clk_i(clk), .rst_i(rst), .tspi_clk_i(sclk), .tspi_cs_ni(cs_n), .tspi_mosi_i(mosi),
        .tspi_miso_o(miso2), .tspi_miso_oe_o(oe2), .addr_o(addr2), .wr_en_o(wr2),
        .wdata_o(wdata2), .rd_en_o(rd2), .rdata_i(rdata2), .busy_o(busy2)
    );

    typedef struct packed {
        logic       rd;
        logic [6:0] addr;
        logic [7:0] data;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs2_q[$];
    int  total = 0;
    int  bad   = 0;

    always @(negedge clk) begin
        ev_t got, want;
        if (!rst) begin
            if (wr_en || rd_en) begin
                got = {rd_en, addr, (wr_en ? wdata : 8'h00)};
                total++;
                if (wr_en && rd_en) begin
                    bad++;
                    $display("FAIL strobe_both wr=%0b rd=%0b required one", wr_en, rd_en);
                end else if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL strobe_unexpected got rd=%0b addr=%h data=%h required none",
                             got.rd, got.addr, got.data);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        bad++;
                        $display("FAIL strobe got rd=%0b addr=%h data=%h required rd=%0b addr=%h data=%h",
                                 got.rd, got.addr, got.data, want.rd, want.addr, want.data);
                    end
                end
            end
            if (!oe) begin
                total++;
                if (miso !== 1'b0) begin
                    bad++;
                    $display("FAIL miso_idle got %b required 0", miso);
                end
            end
            if (wr2) obs2_q.push_back({1'b0, addr2, wdata2});
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic spi_byte(input logic [7:0] tx, input int nbits,
                            output logic [7:0] rx, output int oe_cnt);
        rx     = 8'h00;
        oe_cnt = 0;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = tx[i];
            repeat (4) @(negedge clk);
            rx[i] = miso;
            if (oe) oe_cnt++;
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({miso, oe, addr, wr_en, wdata, rd_en, busy} !== 20'h0) begin
            bad++;
            $display("FAIL reset_outputs got %h required 0", {miso, oe, addr, wr_en, wdata, rd_en, busy});
        end
        rst = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_write();
        logic [7:0] rx;
        int oe_cnt;
        exp_q.push_back({1'b0, 7'h15, 8'hA5});
        cs_low();
        spi_byte(8'h15, 8, rx, oe_cnt);
        total++;
        if (oe_cnt !== 0) begin bad++; $display("FAIL write_cmd_oe got %0d required 0", oe_cnt); end
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL write_busy got %b required 1", busy); end
        spi_byte(8'hA5, 8, rx, oe_cnt);
        total++;
        if (oe_cnt !== 0) begin bad++; $display("FAIL write_data_oe got %0d required 0", oe_cnt); end
        cs_high();
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL write_pending got %0d required 0", exp_q.size()); exp_q.delete();
        end
    endtask

    task automatic test_read();
        logic [7:0] rx;
        int oe_cnt;
        exp_q.push_back({1'b1, 7'h15, 8'h00});
        cs_low();
        spi_byte(8'h95, 8, rx, oe_cnt);
        total++;
        if (oe_cnt !== 0) begin bad++; $display("FAIL read_cmd_oe got %0d required 0", oe_cnt); end
        exp_q.push_back({1'b1, 7'h16, 8'h00});
        spi_byte(8'h00, 8, rx, oe_cnt);
        total++;
        if (rx !== 8'h4F) begin bad++; $display("FAIL read_data got %h required 4f", rx); end
        total++;
        if (oe_cnt !== 8) begin bad++; $display("FAIL read_data_oe got %0d required 8", oe_cnt); end
        cs_high();
        total++;
        if (oe !== 1'b0) begin bad++; $display("FAIL read_oe_after got %b required 0", oe); end
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL read_pending got %0d required 0", exp_q.size()); exp_q.delete();
        end
    endtask

    task automatic test_burst_wrap();
        logic [7:0] rx;
        int oe_cnt;
        ev_t want2;
        obs2_q.delete();
        cs_low();
        spi_byte(8'h7E, 8, rx, oe_cnt);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back({1'b0, 7'(8'h7E + k), 8'(k + 1)});
            spi_byte(8'(k + 1), 8, rx, oe_cnt);
        end
        cs_high();
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL burst_pending got %0d required 0", exp_q.size()); exp_q.delete();
        end
        total++;
        if (obs2_q.size() != 3) begin
            bad++; $display("FAIL fixed_count got %0d required 3", obs2_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                want2 = {1'b0, 7'h7E, 8'(k + 1)};
                total++;
                if (obs2_q[k] !== want2) begin
                    bad++;
                    $display("FAIL fixed_write got addr=%h data=%h required addr=7e data=%h",
                             obs2_q[k].addr, obs2_q[k].data, want2.data);
                end
            end
        end
    endtask

    task automatic test_read_burst();
        logic [7:0] rx;
        logic [7:0] want;
        int oe_cnt;
        exp_q.push_back({1'b1, 7'h00, 8'h00});
        cs_low();
        spi_byte(8'h80, 8, rx, oe_cnt);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back({1'b1, 7'(k + 1), 8'h00});
            spi_byte(8'h00, 8, rx, oe_cnt);
            want = 8'h5A ^ 8'(k);
            total++;
            if (rx !== want) begin bad++; $display("FAIL rburst_data got %h required %h", rx, want); end
        end
        cs_high();
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL rburst_pending got %0d required 0", exp_q.size()); exp_q.delete();
        end
    endtask

    task automatic test_abort();
        logic [7:0] rx;
        int oe_cnt;
        cs_low();
        spi_byte(8'h10, 8, rx, oe_cnt);
        spi_byte(8'hFF, 5, rx, oe_cnt);
        cs_high();
        exp_q.push_back({1'b0, 7'h02, 8'h77});
        cs_low();
        spi_byte(8'h02, 8, rx, oe_cnt);
        spi_byte(8'h77, 8, rx, oe_cnt);
        cs_high();
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL abort_pending got %0d required 0", exp_q.size()); exp_q.delete();
        end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] rx;
        int oe_cnt;
        exp_q.push_back({1'b1, 7'h15, 8'h00});
        cs_low();
        spi_byte(8'h95, 8, rx, oe_cnt);
        spi_byte(8'h00, 3, rx, oe_cnt);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({miso, oe, addr, wr_en, wdata, rd_en, busy} !== 20'h0) begin
            bad++;
            $display("FAIL midreset_outputs got %h required 0", {miso, oe, addr, wr_en, wdata, rd_en, busy});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        spi_byte(8'h05, 8, rx, oe_cnt);
        spi_byte(8'h66, 8, rx, oe_cnt);
        total++;
        if (oe_cnt !== 0) begin bad++; $display("FAIL midreset_oe got %0d required 0", oe_cnt); end
        cs_high();
        exp_q.push_back({1'b0, 7'h05, 8'h66});
        cs_low();
        spi_byte(8'h05, 8, rx, oe_cnt);
        spi_byte(8'h66, 8, rx, oe_cnt);
        cs_high();
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL midreset_pending got %0d required 0", exp_q.size()); exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_burst_wrap();
        test_read_burst();
        test_abort();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
